// File: rtl/alu_pkg.sv
// Shared types for the add/sub issue stage: op encodings, FSM states, queued request layout.
package alu_pkg;
    localparam int   ALU_W  = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic             op;
        logic             acc;
    } req_t;
endpackage

// File: rtl/alu_req_fifo.sv
// Small synchronous request FIFO; pointers carry one extra wrap bit to tell full from empty.
module alu_req_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage for the sign-magnitude add/sub unit: queues requests, normalises operands so the
// unit only subtracts the smaller magnitude from the larger, captures results and chains via acc.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int           W          = ALU_W,
    parameter int           FIFO_DEPTH = 2,
    parameter logic [W-1:0] ACC_RESET  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_op,
    input  logic         in_acc,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_o,
    input  logic [W-1:0] alu_out,
    input  logic         alu_avf,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_out,
    output logic         res_avf
);
    localparam int REQ_W = $bits(req_t);

    req_t         push_req;
    req_t         head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         fifo_push;
    logic         fifo_pop;
    state_t       state;
    logic [W-1:0] acc;
    logic         eff_add_q;

    // in_ready only looks at registered fullness, so a pop frees a slot one cycle later
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign fifo_pop  = !fifo_empty && (state == IDLE || (state == RESP && res_ready));

    always_comb begin
        push_req     = '0;
        push_req.a   = in_a;
        push_req.b   = in_b;
        push_req.op  = in_op;
        push_req.acc = in_acc;
    end

    alu_req_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(REQ_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (push_req),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    logic [W-1:0] op_a;
    logic         sa, sb, eff_sub, swap_s;
    logic [W-2:0] ma, mb;
    logic [W-1:0] norm_a, norm_b;

    // Larger magnitude always goes to alu_a; operand signs alone steer the unit to add or subtract
    always_comb begin
        op_a    = head.acc ? acc : head.a;
        sa      = op_a[W-1];
        sb      = head.b[W-1];
        ma      = op_a[W-2:0];
        mb      = head.b[W-2:0];
        eff_sub = (head.op == OP_ADD) ? (sa != sb) : (sa == sb);
        swap_s  = 1'b0;
        norm_a  = {sa, ma};
        norm_b  = {sa, mb};
        if (eff_sub) begin
            if (ma >= mb) begin
                norm_b = {~sa, mb};
            end else begin
                swap_s = head.op ? ~sb : sb;
                norm_a = {swap_s, mb};
                norm_b = {~swap_s, ma};
            end
        end
    end

    logic [W-1:0] cap_out;
    assign cap_out = (alu_out[W-2:0] == '0) ? '0 : alu_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= ACC_RESET;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_o     <= 1'b0;
            eff_add_q <= 1'b0;
            res_out   <= '0;
            res_avf   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        alu_a     <= norm_a;
                        alu_b     <= norm_b;
                        alu_o     <= OP_ADD;
                        eff_add_q <= !eff_sub;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    res_out   <= cap_out;
                    res_avf   <= eff_add_q && alu_avf;
                    acc       <= cap_out;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (fifo_pop) begin
                            alu_a     <= norm_a;
                            alu_b     <= norm_b;
                            alu_o     <= OP_ADD;
                            eff_add_q <= !eff_sub;
                            state     <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural model of the sign-magnitude add/sub unit.
module tb_alu_issue_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_op, in_acc;
    logic [3:0] in_a, in_b;
    logic [3:0] alu_a, alu_b, alu_out, res_out;
    logic       alu_o, alu_avf, res_valid, res_ready, res_avf;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_op(in_op), .in_acc(in_acc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o),
        .alu_out(alu_out), .alu_avf(alu_avf),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out), .res_avf(res_avf)
    );

    // Unit model: equal signs add magnitudes, otherwise |a|-|b|; result takes alu_a's sign
    logic [3:0] sum4;
    always_comb begin
        sum4 = 4'd0;
        if (alu_a[3] == alu_b[3]) begin
            sum4    = {1'b0, alu_a[2:0]} + {1'b0, alu_b[2:0]};
            alu_avf = sum4[3];
        end else begin
            sum4    = {1'b0, alu_a[2:0]} - {1'b0, alu_b[2:0]};
            alu_avf = 1'b1;
        end
        alu_out = {alu_a[3], sum4[2:0]};
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] a, b;
        logic       op;
        logic [3:0] ea, eb, eo;
        logic       eavf;
    } vec_t;
    vec_t tv[10];

    logic [3:0] got[$];
    int         got_t[$];

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_acc = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Records handshaken results starting at the current negedge, for a fixed cycle budget
    task automatic collect(input int budget);
        got.delete(); got_t.delete();
        for (int c = 0; c < budget; c++) begin
            if (res_valid && res_ready) begin
                got.push_back(res_out);
                got_t.push_back(c);
            end
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic op, input logic ac);
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_acc = ac;
    endtask

    initial begin
        int accepted;
        res_ready = 1'b1;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_acc = 1'b0;
        #2;
        chk("rst_alu_a", alu_a, 4'h0);
        chk("rst_alu_b", alu_b, 4'h0);
        chk("rst_alu_o", alu_o, 1'b0);
        chk("rst_res_out", res_out, 4'h0);
        chk("rst_res_avf", res_avf, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        do_reset();

        tv[0] = '{4'b0101, 4'b1011, 1'b0, 4'b0101, 4'b1011, 4'b0010, 1'b0};
        tv[1] = '{4'b0011, 4'b0101, 1'b1, 4'b1101, 4'b0011, 4'b1010, 1'b0};
        tv[2] = '{4'b0110, 4'b0011, 1'b0, 4'b0110, 4'b0011, 4'b0001, 1'b1};
        tv[3] = '{4'b1011, 4'b0011, 1'b0, 4'b1011, 4'b0011, 4'b0000, 1'b0};
        tv[4] = '{4'b1010, 4'b1001, 1'b1, 4'b1010, 4'b0001, 4'b1001, 1'b0};
        tv[5] = '{4'b0001, 4'b1110, 1'b1, 4'b0001, 4'b0110, 4'b0111, 1'b0};
        tv[6] = '{4'b1100, 4'b1101, 1'b0, 4'b1100, 4'b1101, 4'b1001, 1'b1};
        tv[7] = '{4'b0010, 4'b0110, 1'b0, 4'b0010, 4'b0110, 4'b0000, 1'b1};
        tv[8] = '{4'b1001, 4'b0101, 1'b0, 4'b0101, 4'b1001, 4'b0100, 1'b0};
        tv[9] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000, 4'b0000, 1'b0};

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tv[i].a, tv[i].b, tv[i].op, 1'b0);
            chk($sformatf("v%0d_in_ready", i), in_ready, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid_c1", i), res_valid, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_valid_c2", i), res_valid, 1'b0);
            chk($sformatf("v%0d_alu_a", i), alu_a, tv[i].ea);
            chk($sformatf("v%0d_alu_b", i), alu_b, tv[i].eb);
            chk($sformatf("v%0d_alu_o", i), alu_o, 1'b0);
            @(negedge clk);
            chk($sformatf("v%0d_valid_c3", i), res_valid, 1'b1);
            chk($sformatf("v%0d_res_out", i), res_out, tv[i].eo);
            chk($sformatf("v%0d_res_avf", i), res_avf, tv[i].eavf);
        end

        // Accumulator chaining, back-to-back; in_a must be ignored
        do_reset();
        drive(4'b0111, 4'b0010, 1'b0, 1'b1);
        @(negedge clk);
        drive(4'b0111, 4'b0010, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        collect(12);
        chk("acc_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("acc_res0", got[0], 4'b0010);
            chk("acc_res1", got[1], 4'b0100);
            chk("acc_spacing", got_t[1] - got_t[0], 2);
        end

        // Backpressure: 4 offered with res_ready low, only 3 fit
        do_reset();
        res_ready = 1'b0;
        accepted = 0;
        for (int k = 0; k < 4; k++) begin
            drive(4'(2 * k + 1), 4'b0001, 1'b0, 1'b0);
            if (in_ready) accepted++;
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            chk("bp_in_ready_low", in_ready, 1'b0);
            @(negedge clk);
        end
        chk("bp_accepted", accepted, 3);
        in_valid = 1'b0;
        res_ready = 1'b1;
        collect(16);
        chk("bp_count", got.size(), 3);
        if (got.size() == 3) begin
            chk("bp_res0", got[0], 4'b0010);
            chk("bp_res1", got[1], 4'b0100);
            chk("bp_res2", got[2], 4'b0110);
            chk("bp_spacing1", got_t[1] - got_t[0], 2);
            chk("bp_spacing2", got_t[2] - got_t[1], 2);
        end

        // Reset while executing with another request queued
        do_reset();
        drive(4'b0011, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        collect(6);
        chk("rx_pre_count", got.size(), 1);
        drive(4'b0101, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(4'b0110, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rx_res_valid", res_valid, 1'b0);
        chk("rx_in_ready", in_ready, 1'b1);
        chk("rx_alu_a", alu_a, 4'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        collect(10);
        chk("rx_no_results", got.size(), 0);
        drive(4'b0111, 4'b0001, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        collect(8);
        chk("rx_acc_count", got.size(), 1);
        if (got.size() == 1)
            chk("rx_acc_zero", got[0], 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
